test_status_mmio: RTL

- Memory-mapped responder on the core's data-memory bus. Core-side test programs report completion by writing to it, riscv-tests "tohost" style.
- Decides the verdict (PASS/FAIL/TIMEOUT) in hardware, exposes it on done/pass/leds, and provides read-back registers.
- Also supports PC-match verdicts (pass/fail addresses) plus a cycle watchdog. Self-checking then works on FPGA with no simulator monitor.
- Sits beside data memory inside Core. Core decodes the address range and steers wen/ren here.

---
 rtl/test_status_pkg.sv | 36 +++
 rtl/status_watchdog.sv | 37 +++
 rtl/test_status_mmio.sv | 120 ++++++++++++
 3 files changed

// File: rtl/test_status_pkg.sv
// Shared definitions for the test-status MMIO responder.
//   state_t        : verdict state, also exposed on STATUS[1:0] and leds[5:4]
//   OFF_*          : word offsets of the register window relative to BASE_ADDR
//   tohost_decode  : classifies a TOHOST store into pass / fail / ignore
package test_status_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_t;

   localparam logic [31:0] OFF_TOHOST  = 32'h0000_0000;
   localparam logic [31:0] OFF_STATUS  = 32'h0000_0004;
   localparam logic [31:0] OFF_CYCLE   = 32'h0000_0008;
   localparam logic [31:0] OFF_PASS_PC = 32'h0000_000C;
   localparam logic [31:0] OFF_FAIL_PC = 32'h0000_0010;

   typedef struct packed {
      logic       is_pass;
      logic       is_fail;
      logic [7:0] code;
   } tohost_t;

   // riscv-tests convention: 1 is pass, any other odd value is a failure
   // carrying the test number in the upper bits, even values are not verdicts.
   function automatic tohost_t tohost_decode(input logic [31:0] data);
      tohost_t r;
      r.is_pass = (data == 32'd1);
      r.is_fail = data[0] && (data != 32'd1);
      r.code    = data[8:1];
      return r;
   endfunction

endpackage

// File: rtl/status_watchdog.sv
// Saturating RUN-cycle counter with terminal-count timeout.
//   clk, rst : clock, synchronous active-high reset
//   en       : counter is live (verdict state is RUN)
//   hold     : a verdict is being taken this edge; do not count it
//   cycle    : cycles spent in RUN, saturates at all-ones
//   timeout  : combinational, high in the cycle where the terminal count is reached
module status_watchdog
   import test_status_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        hold,
   output logic [31:0] cycle,
   output logic        timeout
);

   // Wraps to all-ones when the watchdog is disabled; the enable term masks it.
   localparam logic [31:0] TC_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic        TC_ON   = (TIMEOUT_CYCLES != 0);

   logic [31:0] cycle_q;

   assign cycle   = cycle_q;
   assign timeout = TC_ON && en && (cycle_q == TC_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= '0;
      end else if (en && !hold && (cycle_q != 32'hFFFF_FFFF)) begin
         cycle_q <= cycle_q + 32'd1;
      end
   end

endmodule

// File: rtl/test_status_mmio.sv
// Memory-mapped test verdict block ("tohost" style) with PC-match verdicts
// and a cycle watchdog.
//   clk, rst        : clock, synchronous active-high reset
//   addr, wdata     : byte address and store data from the core
//   wen, ren        : store / load strobes, already range-qualified
//   rdata           : registered load data, holds between loads
//   pc              : current program counter for PASS_PC / FAIL_PC matching
//   done, pass      : verdict reached / verdict is PASS
//   leds            : {state, fail_code[3:0]}
//
// state      | meaning
// -----------+-------------------------------------------
// ST_RUN     | test executing, counting cycles
// ST_PASS    | TOHOST==1 or pc hit PASS_PC (terminal)
// ST_FAIL    | odd TOHOST!=1 or pc hit FAIL_PC (terminal)
// ST_TIMEOUT | watchdog expired (terminal)
module test_status_mmio
   import test_status_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter logic [31:0] PASS_PC_RST    = 32'hFFFF_FFFF,
   parameter logic [31:0] FAIL_PC_RST    = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        wen,
   input  logic        ren,
   output logic [31:0] rdata,
   input  logic [31:0] pc,
   output logic        done,
   output logic        pass,
   output logic [5:0]  leds
);

   state_t      state_q, state_d;
   logic [7:0]  fail_code_q, fail_code_d;
   logic [31:0] pass_pc_q, fail_pc_q, rdata_q;
   logic [31:0] cycle;
   logic        timeout;
   logic [31:0] off_w, rd_val;
   logic        tohost_wr, pass_pc_hit, fail_pc_hit;
   tohost_t     th;

   // Byte lane bits are don't-care; mask rather than slice so every address bit is decoded.
   assign off_w     = (addr - BASE_ADDR) & 32'hFFFF_FFFC;
   assign tohost_wr = wen && (off_w == OFF_TOHOST);
   assign th        = tohost_decode(wdata);

   // Compares use the registered PC values, so a same-cycle write only counts next cycle.
   assign pass_pc_hit = (pass_pc_q != 32'hFFFF_FFFF) && (pc == pass_pc_q);
   assign fail_pc_hit = (fail_pc_q != 32'hFFFF_FFFF) && (pc == fail_pc_q);

   always_comb begin
      state_d     = state_q;
      fail_code_d = fail_code_q;
      if (state_q == ST_RUN) begin
         if (tohost_wr && th.is_fail) begin
            state_d     = ST_FAIL;
            fail_code_d = th.code;
         end else if (fail_pc_hit) begin
            state_d     = ST_FAIL;
            fail_code_d = 8'd0;
         end else if (tohost_wr && th.is_pass) begin
            state_d = ST_PASS;
         end else if (pass_pc_hit) begin
            state_d = ST_PASS;
         end else if (timeout) begin
            state_d = ST_TIMEOUT;
         end
      end
   end

   // The verdict edge itself is not counted, so CYCLE freezes at the last RUN value.
   status_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .en      (state_q == ST_RUN),
      .hold    (state_d != state_q),
      .cycle   (cycle),
      .timeout (timeout)
   );

   always_comb begin
      rd_val = 32'd0;
      case (off_w)
         OFF_STATUS:  rd_val = {22'd0, fail_code_q, state_q};
         OFF_CYCLE:   rd_val = cycle;
         OFF_PASS_PC: rd_val = pass_pc_q;
         OFF_FAIL_PC: rd_val = fail_pc_q;
         default:     rd_val = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         fail_code_q <= 8'd0;
         pass_pc_q   <= PASS_PC_RST;
         fail_pc_q   <= FAIL_PC_RST;
         rdata_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         fail_code_q <= fail_code_d;
         if (wen && (off_w == OFF_PASS_PC)) pass_pc_q <= wdata;
         if (wen && (off_w == OFF_FAIL_PC)) fail_pc_q <= wdata;
         if (ren) rdata_q <= rd_val;
      end
   end

   assign rdata = rdata_q;
   assign done  = (state_q != ST_RUN);
   assign pass  = (state_q == ST_PASS);
   assign leds  = {state_q, fail_code_q[3:0]};

endmodule
